// File: rtl/music_pkg.sv
// Shared definitions for the music player: song table, beat address width,
// and the transport state encoding seen on the beat_sequencer state port.
package music_pkg;

  localparam int BEAT_W     = 12;
  localparam int NUM_SONGS  = 4;
  localparam int SONG_IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Regions of the shared note ROM; entries must not cross 2^BEAT_W.
  localparam logic [BEAT_W-1:0] SONG_START [NUM_SONGS] = '{12'd0, 12'd8, 12'd12, 12'd28};
  localparam logic [BEAT_W-1:0] SONG_LEN   [NUM_SONGS] = '{12'd8, 12'd4, 12'd16, 12'd8};

  function automatic logic [BEAT_W-1:0] song_start(input logic [SONG_IDX_W-1:0] idx);
    return SONG_START[idx];
  endfunction

  function automatic logic [BEAT_W-1:0] song_last(input logic [SONG_IDX_W-1:0] idx);
    return SONG_START[idx] + SONG_LEN[idx] - BEAT_W'(1);
  endfunction

endpackage

// File: rtl/beat_divider.sv
// Tempo divider: counts clk cycles while enabled and flags the terminal count
// of the current beat period (normal, or stretched by SLOW_MULT when slow).
// The compare is ">=" so that dropping slow late in a long beat ends that beat
// on the next enabled cycle instead of running the counter around.
module beat_divider
  import music_pkg::*;
#(
  parameter int BEAT_DIV  = 12_500_000,
  parameter int SLOW_MULT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  input  logic slow_i,
  output logic term_o,
  output logic tick_o
);

  localparam int PERIOD_SLOW = BEAT_DIV * SLOW_MULT;
  localparam int CNT_W       = (PERIOD_SLOW > 1) ? $clog2(PERIOD_SLOW) : 1;
  localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(BEAT_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(PERIOD_SLOW - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] last_cnt;

  // Period select, terminal detect and next count.
  always_comb begin
    last_cnt  = slow_i ? LAST_SLOW : LAST_FAST;
    term_o    = (div_cnt_q >= last_cnt);
    tick_o    = en_i && term_o;
    div_cnt_d = div_cnt_q;
    if (clr_i || tick_o) begin
      div_cnt_d = '0;
    end else if (en_i) begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Transport controller: play/pause/stop/song-select FSM, song latch and the
// note-ROM beat address. Optional macro SONG_REPEAT_EN: when defined, the
// song loops from its start after the last beat instead of stopping in DONE.
//
//   state | meaning
//   IDLE  | stopped; follows song_sel, ibeat parked at song start
//   PLAY  | divider running, ibeat advances on each tick
//   PAUSE | divider and ibeat frozen mid-beat
//   DONE  | last beat reached; ibeat held, follows song_sel for replay
module beat_sequencer
  import music_pkg::*;
#(
  parameter int BEAT_DIV  = 12_500_000,
  parameter int SLOW_MULT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  stop,
  input  logic                  slow,
  input  logic [SONG_IDX_W-1:0] song_sel,
  output logic [BEAT_W-1:0]     ibeat,
  output logic                  beat_tick,
  output logic [1:0]            state,
  output logic                  song_done
);

  state_t                  state_q, state_d;
  logic [SONG_IDX_W-1:0]   cur_song_q, cur_song_d;
  logic [BEAT_W-1:0]       ibeat_q, ibeat_d;
  logic                    beat_tick_q, beat_tick_d;
  logic                    song_done_q, song_done_d;
  logic                    div_en, div_clr, div_term, div_tick;
  logic                    last_beat;

  // A play pulse in PLAY freezes the divider unless the beat ends this cycle,
  // in which case the advance is taken first and PAUSE follows.
  assign div_en  = (state_q == ST_PLAY) && !stop && (!play || div_term);
  assign div_clr = stop || (state_q == ST_IDLE) || ((state_q == ST_DONE) && play);

  beat_divider #(
    .BEAT_DIV  (BEAT_DIV),
    .SLOW_MULT (SLOW_MULT)
  ) u_beat_divider (
    .clk    (clk),
    .reset  (reset),
    .en_i   (div_en),
    .clr_i  (div_clr),
    .slow_i (slow),
    .term_o (div_term),
    .tick_o (div_tick)
  );

  // Next-state and registered-output logic for the transport FSM.
  always_comb begin
    state_d     = state_q;
    cur_song_d  = cur_song_q;
    ibeat_d     = ibeat_q;
    beat_tick_d = 1'b0;
    song_done_d = 1'b0;
    last_beat   = (ibeat_q == song_last(cur_song_q));
    if (stop) begin
      state_d = ST_IDLE;
      ibeat_d = song_start(cur_song_q);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cur_song_d = song_sel;
          ibeat_d    = song_start(song_sel);
          if (play) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (play) state_d = ST_PAUSE;
          if (div_tick) begin
            if (last_beat) begin
              song_done_d = 1'b1;
`ifdef SONG_REPEAT_EN
              ibeat_d     = song_start(cur_song_q);
              beat_tick_d = 1'b1;
`else
              state_d     = ST_DONE;
`endif
            end else begin
              ibeat_d     = ibeat_q + BEAT_W'(1);
              beat_tick_d = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (play) state_d = ST_PLAY;
        end
        ST_DONE: begin
          cur_song_d = song_sel;
          if (play) begin
            state_d = ST_PLAY;
            ibeat_d = song_start(song_sel);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, song latch, beat address and strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_song_q  <= '0;
      ibeat_q     <= SONG_START[0];
      beat_tick_q <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_song_q  <= cur_song_d;
      ibeat_q     <= ibeat_d;
      beat_tick_q <= beat_tick_d;
      song_done_q <= song_done_d;
    end
  end

  assign ibeat     = ibeat_q;
  assign beat_tick = beat_tick_q;
  assign state     = state_q;
  assign song_done = song_done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer with a short beat period (4 cycles, x2 slow).
// Expected beats are queued as stimulus is applied and popped on each beat_tick.
module tb_beat_sequencer;
  import music_pkg::*;

  localparam int BEAT_DIV  = 4;
  localparam int SLOW_MULT = 2;

  logic                  clk = 1'b0;
  logic                  reset, play, stop, slow;
  logic [SONG_IDX_W-1:0] song_sel;
  logic [BEAT_W-1:0]     ibeat;
  logic                  beat_tick;
  logic [1:0]            state;
  logic                  song_done;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic [BEAT_W-1:0] ibeat;
    int                gap;
    logic              done;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  beat_sequencer #(.BEAT_DIV(BEAT_DIV), .SLOW_MULT(SLOW_MULT)) dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .stop      (stop),
    .slow      (slow),
    .song_sel  (song_sel),
    .ibeat     (ibeat),
    .beat_tick (beat_tick),
    .state     (state),
    .song_done (song_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input int ib, input int gap, input logic done);
    exp_t e;
    e.ibeat = BEAT_W'(ib);
    e.gap   = gap;
    e.done  = done;
    sb_q.push_back(e);
  endtask

  task automatic wait_tick(input string tag);
    exp_t e;
    int   n;
    bit   seen;
    e    = sb_q.pop_front();
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (beat_tick === 1'b1) seen = 1;
    end
    chk({tag, ".seen"}, 32'(seen), 32'd1);
    chk({tag, ".gap"}, n, e.gap);
    chk({tag, ".ibeat"}, 32'(ibeat), 32'(e.ibeat));
    chk({tag, ".done"}, 32'(song_done), 32'(e.done));
  endtask

  task automatic pulse_play();
    play = 1'b1;
    step();
    play = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".state"}, 32'(state), 32'd0);
    chk({tag, ".ibeat"}, 32'(ibeat), 32'd0);
    chk({tag, ".tick"}, 32'(beat_tick), 32'd0);
    chk({tag, ".done"}, 32'(song_done), 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    reset = 1'b1; play = 1'b0; stop = 1'b0; slow = 1'b0; song_sel = 2'd1;
    steps(2);
    chk_reset_vals("rst");

    // IDLE follows song_sel with one cycle of latency
    reset = 1'b0;
    step();
    chk("idle.ibeat", 32'(ibeat), 32'd8);
    chk("idle.state", 32'(state), 32'd0);

    // song1 playback at normal tempo
    pulse_play();
    chk("play.state", 32'(state), 32'd1);
    chk("play.ibeat", 32'(ibeat), 32'd8);
    push_beat(9, 4, 0); push_beat(10, 4, 0); push_beat(11, 4, 0);
    wait_tick("s1b9"); wait_tick("s1b10"); wait_tick("s1b11");

`ifdef SONG_REPEAT_EN
    push_beat(8, 4, 1);
    wait_tick("s1wrap");
    chk("s1wrap.state", 32'(state), 32'd1);
    pulse_stop();
    song_sel = 2'd0;
    step();
    pulse_play();
    for (int i = 1; i < 8; i++) push_beat(i, 4, 0);
    push_beat(0, 4, 1);
    for (int i = 0; i < 8; i++) wait_tick("s0rep");
    chk("s0rep.state", 32'(state), 32'd1);
    step();
    chk("s0rep.done_clr", 32'(song_done), 32'd0);
    pulse_stop();
`else
    n = 0;
    while (song_done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("done.gap", n, 32'd4);
    chk("done.state", 32'(state), 32'd3);
    chk("done.ibeat", 32'(ibeat), 32'd11);
    chk("done.tick", 32'(beat_tick), 32'd0);
    step();
    chk("done.pulse1", 32'(song_done), 32'd0);
    n = 0;
    repeat (12) begin
      step();
      if (beat_tick !== 1'b0 || song_done !== 1'b0) n++;
    end
    chk("done.quiet", n, 32'd0);
    chk("done.hold", 32'(ibeat), 32'd11);
    pulse_play();
    chk("replay.ibeat", 32'(ibeat), 32'd8);
    chk("replay.state", 32'(state), 32'd1);
    pulse_stop();
    chk("replay.stop", 32'(ibeat), 32'd8);
`endif

    // slow tempo, then slow falling late in a long beat
    song_sel = 2'd0;
    step();
    slow = 1'b1;
    pulse_play();
    push_beat(1, 8, 0); push_beat(2, 8, 0);
    wait_tick("slow1"); wait_tick("slow2");
    steps(5);
    slow = 1'b0;
    step();
    chk("slowfall.tick", 32'(beat_tick), 32'd1);
    chk("slowfall.ibeat", 32'(ibeat), 32'd3);

    // pause at div_cnt=2, hold 20 cycles, resume the partial beat
    steps(2);
    pulse_play();
    chk("pause.state", 32'(state), 32'd2);
    bad = 0;
    repeat (20) begin
      step();
      if (beat_tick !== 1'b0 || ibeat !== 12'd3 || state !== 2'd2) bad++;
    end
    chk("pause.frozen", bad, 32'd0);
    pulse_play();
    chk("resume.state", 32'(state), 32'd1);
    push_beat(4, 2, 0);
    wait_tick("resume");

    // play coinciding with the terminal count: advance, then PAUSE
    steps(3);
    pulse_play();
    chk("tickpause.tick", 32'(beat_tick), 32'd1);
    chk("tickpause.ibeat", 32'(ibeat), 32'd5);
    chk("tickpause.state", 32'(state), 32'd2);

    // stop wins over play; stop returns to the latched song, not song_sel
    song_sel = 2'd2;
    play = 1'b1; stop = 1'b1;
    step();
    play = 1'b0; stop = 1'b0;
    chk("stopplay.state", 32'(state), 32'd0);
    chk("stopplay.ibeat", 32'(ibeat), 32'd0);
    step();
    chk("idle2.ibeat", 32'(ibeat), 32'd12);

    // song_sel changes during PLAY are ignored
    pulse_play();
    chk("s2.ibeat", 32'(ibeat), 32'd12);
    song_sel = 2'd3;
    push_beat(13, 4, 0);
    wait_tick("s2b13");
    chk("s2.state", 32'(state), 32'd1);
    pulse_stop();
    chk("s2stop.ibeat", 32'(ibeat), 32'd12);
    chk("s2stop.state", 32'(state), 32'd0);
    step();
    chk("idle3.ibeat", 32'(ibeat), 32'd28);

    // reset mid-beat
    pulse_play();
    chk("s3.ibeat", 32'(ibeat), 32'd28);
    steps(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("midrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
